// File: rtl/core_fetch_buf.sv
// rtl/core_fetch_buf.sv - instruction fetch unit with PC, redirect and DEPTH-entry decode buffer
module core_fetch_buf #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect_en,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_req_en,
    output logic [XLEN-1:0]   inst_req_addr,
    output logic [XLEN/8-1:0] inst_req_mask,
    input  logic              inst_rsp_done,
    input  logic              inst_rsp_valid,
    input  logic [XLEN-1:0]   inst_rsp_data,
    output logic              rdy,
    output logic              dec_valid,
    output logic [XLEN-1:0]   dec_inst,
    output logic [XLEN-1:0]   dec_pc,
    output logic              dec_fault,
    input  logic              dec_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] pc;
    logic            halted;
    logic [XLEN-1:0] inst_mem  [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic            fault_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // rst gating keeps the request quiet for the whole reset pulse, not just after the edge
    assign inst_req_en   = !rst && en && !halted && !redirect_en && (count < DEPTH_C);
    assign inst_req_addr = pc;
    assign inst_req_mask = '1;

    assign push = inst_req_en && inst_rsp_done;
    assign pop  = dec_valid && dec_rdy && !redirect_en;
    assign rdy  = push;

    assign dec_valid = (count != '0);
    assign dec_inst  = inst_mem[rd_ptr];
    assign dec_pc    = pc_mem[rd_ptr];
    assign dec_fault = fault_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i]  <= '0;
                pc_mem[i]    <= '0;
                fault_mem[i] <= 1'b0;
            end
        end else if (redirect_en) begin
            pc     <= {redirect_pc[XLEN-1:2], 2'b00};
            halted <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr]  <= inst_rsp_data;
                pc_mem[wr_ptr]    <= pc;
                fault_mem[wr_ptr] <= !inst_rsp_valid;
                wr_ptr            <= wr_ptr + AW'(1);
                // a faulting fetch stalls on its own address until a redirect
                if (inst_rsp_valid) begin
                    pc <= pc + XLEN'(4);
                end else begin
                    halted <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_fetch_buf.sv
// tb/tb_core_fetch_buf.sv - scoreboard bench for core_fetch_buf against a queue-based fetch model
module tb_core_fetch_buf;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            redirect_en;
    logic [31:0]     redirect_pc;
    logic            inst_req_en;
    logic [31:0]     inst_req_addr;
    logic [3:0]      inst_req_mask;
    logic            inst_rsp_done;
    logic            inst_rsp_valid;
    logic [31:0]     inst_rsp_data;
    logic            rdy;
    logic            dec_valid;
    logic [31:0]     dec_inst;
    logic [31:0]     dec_pc;
    logic            dec_fault;
    logic            dec_rdy;

    core_fetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .en(en),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .inst_req_en(inst_req_en), .inst_req_addr(inst_req_addr), .inst_req_mask(inst_req_mask),
        .inst_rsp_done(inst_rsp_done), .inst_rsp_valid(inst_rsp_valid), .inst_rsp_data(inst_rsp_data),
        .rdy(rdy), .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_fault(dec_fault), .dec_rdy(dec_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    logic [31:0] m_pc;
    logic        m_halted;
    int          m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: predicts the request each cycle and records expected deliveries
    always @(negedge clk) begin
        logic   m_req;
        logic   comp;
        logic   popd;
        entry_t e;
        #1;
        if (rst) begin
            sb_q.delete();
            m_pc     = RPC;
            m_halted = 1'b0;
            m_cnt    = 0;
        end else begin
            m_req = en && !m_halted && !redirect_en && (m_cnt < DEPTH);
            comp  = m_req && inst_rsp_done;
            check("req_en", 64'(inst_req_en), 64'(m_req));
            if (m_req) check("req_addr", 64'(inst_req_addr), 64'(m_pc));
            check("req_mask", 64'(inst_req_mask), 64'hF);
            check("rdy", 64'(rdy), 64'(comp));
            if (redirect_en) begin
                sb_q.delete();
                m_pc     = redirect_pc & ~32'h3;
                m_halted = 1'b0;
                m_cnt    = 0;
            end else begin
                popd = (m_cnt > 0) && dec_rdy;
                if (comp) begin
                    e.inst  = inst_rsp_data;
                    e.pc    = m_pc;
                    e.fault = !inst_rsp_valid;
                    sb_q.push_back(e);
                    if (inst_rsp_valid) m_pc = m_pc + 32'd4;
                    else m_halted = 1'b1;
                end
                m_cnt = m_cnt + int'(comp) - int'(popd);
            end
        end
    end

    // monitor: compares the buffer head whenever decode sees a valid entry
    always @(negedge clk) begin
        if (!rst) begin
            check("dec_valid", 64'(dec_valid), 64'(sb_q.size() != 0));
            if (dec_valid && sb_q.size() != 0) begin
                check("dec_pc", 64'(dec_pc), 64'(sb_q[0].pc));
                check("dec_fault", 64'(dec_fault), 64'(sb_q[0].fault));
                if (!sb_q[0].fault) check("dec_inst", 64'(dec_inst), 64'(sb_q[0].inst));
                if (dec_rdy && !redirect_en) void'(sb_q.pop_front());
            end
        end
    end

    task automatic drive(input logic e, input logic d, input logic v, input logic r, input int n);
        repeat (n) begin
            @(posedge clk); #2;
            en             = e;
            inst_rsp_done  = d;
            inst_rsp_valid = v;
            dec_rdy        = r;
            redirect_en    = 1'b0;
            inst_rsp_data  = $urandom;
        end
    endtask

    task automatic redirect_to(input logic [31:0] a);
        @(posedge clk); #2;
        redirect_en = 1'b1;
        redirect_pc = a;
        dec_rdy     = 1'b1;
        @(posedge clk); #2;
        redirect_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
        inst_rsp_done = 1'b1; inst_rsp_valid = 1'b1; inst_rsp_data = '0; dec_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_en", 64'(inst_req_en), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_dec_inst", 64'(dec_inst), 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_dec_fault", 64'(dec_fault), 64'd0);
        check("rst_addr", 64'(inst_req_addr), 64'(RPC));
        @(posedge clk); #2;
        rst = 1'b0;
        drive(1, 1, 1, 1, 12);
        drive(1, 1, 1, 0, 8);
        @(negedge clk); #2;
        check("full_req_en", 64'(inst_req_en), 64'd0);
        check("full_dec_valid", 64'(dec_valid), 64'd1);
        drive(1, 1, 1, 1, 8);
        redirect_to(32'h3002);
        @(negedge clk); #2;
        check("redir_dec_valid", 64'(dec_valid), 64'd0);
        check("redir_addr", 64'(inst_req_addr), 64'h3000);
        drive(1, 0, 1, 1, 5);
        drive(0, 0, 1, 1, 2);
        drive(1, 1, 1, 1, 3);
        drive(1, 1, 0, 1, 1);
        drive(1, 1, 1, 1, 4);
        redirect_to(32'h400);
        drive(1, 1, 1, 1, 4);
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            en             = ($urandom_range(0, 9) != 0);
            inst_rsp_done  = $urandom_range(0, 1) == 1;
            inst_rsp_valid = ($urandom_range(0, 15) != 0);
            inst_rsp_data  = $urandom;
            dec_rdy        = $urandom_range(0, 2) != 0;
            redirect_en    = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
        end
        redirect_to(32'h500);
        drive(1, 1, 1, 0, 8);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_dec_valid", 64'(dec_valid), 64'd0);
        check("midrst_req_en", 64'(inst_req_en), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0; dec_rdy = 1'b1;
        @(negedge clk); #2;
        check("post_rst_addr", 64'(inst_req_addr), 64'(RPC));
        check("post_rst_req_en", 64'(inst_req_en), 64'd1);
        drive(1, 1, 1, 1, 6);
        @(negedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_fetch_buf.md
# core_fetch_buf

Parametrised instruction-fetch unit that owns the program counter, issues sequential word reads to instruction memory, and buffers returned instructions in a DEPTH-entry FIFO feeding decode through a valid/ready handshake. It sits between the instruction memory port and the decode stage, replacing the single-register IF/ID latch. It adds branch redirect with buffer flush, fetch-fault tagging with fetch halt, and back-pressure that decouples memory latency from decode stalls.

## Interface
- XLEN, 32, address/instruction width in bits; multiple of 8
- DEPTH, 4, instruction buffer entries; power of two, >= 2
- RESET_PC, 0, PC value loaded on reset; low two bits must be zero

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  fetch enable; 0 suppresses new requests, buffer still drains
- redirect_en  in  1  redirect strobe from branch resolution
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0)
- inst_req_en  out  1  memory read request valid
- inst_req_addr  out  XLEN  read address (current PC)
- inst_req_mask  out  XLEN/8  byte mask, all ones
- inst_rsp_done  in  1  request completes this cycle (qualified by inst_req_en)
- inst_rsp_valid  in  1  completed data is good; 0 = access fault
- inst_rsp_data  in  XLEN  instruction word
- rdy  out  1  a fetch completed and was accepted this cycle
- dec_valid  out  1  buffer head holds an entry
- dec_inst  out  XLEN  head instruction
- dec_pc  out  XLEN  head PC
- dec_fault  out  1  head entry is a fault marker
- dec_rdy  in  1  decode accepts head this cycle

## Operation
- State: pc (XLEN), halted (1), FIFO of {inst, pc, fault} with rd/wr pointers ($clog2(DEPTH) bits, wrap modulo DEPTH) and count ($clog2(DEPTH)+1 bits).
- inst_req_en = en && !halted && !redirect_en && (count < DEPTH); addr = pc; mask all ones; all combinational from state and inputs.
- Completion = inst_req_en && inst_rsp_done. On completion: push {inst_rsp_data, pc, !inst_rsp_valid}; rdy = 1.
  - inst_rsp_valid=1: pc <= pc + 4 (wraps modulo 2^XLEN).
  - inst_rsp_valid=0: pc unchanged, halted <= 1; inst pushed as data driven (don't-care).
- Pop when dec_valid && dec_rdy; rd pointer advances.
- Push and pop in same cycle: count unchanged, both pointers advance; legal when full (push blocked by count<DEPTH only, so full+pop does not push that cycle).
- Redirect (highest priority): pc <= {redirect_pc[XLEN-1:2], 2'b00}; FIFO flushed (pointers, count = 0); halted <= 0; no request issued that cycle, no push, pop ignored (entry discarded).
- en deasserted mid-stream: no new requests; pc held; buffered entries still delivered.
- halted cleared only by redirect or reset.

## Timing
- Reset values: pc = RESET_PC, halted = 0, count = 0, pointers = 0 -> inst_req_en = 0 while rst high, dec_valid = 0, dec_inst/dec_pc/dec_fault = 0 (storage cleared), rdy = 0.
- First request: cycle after rst deasserts, if en.
- Fetch-to-decode latency: completion in cycle N -> dec_valid in N+1 (if buffer was empty).
- Zero-wait memory (done same cycle as request) sustains one instruction per cycle with dec_rdy held high.
- Redirect in cycle N: dec_valid = 0 in N+1, inst_req_addr = redirect_pc in N+1.
- Request held with constant addr until done or redirect; a redirect abandons any in-flight request (memory must tolerate withdrawn en).
- dec_* outputs are registered-storage reads, stable while dec_valid && !dec_rdy.

## Test plan
- Reset RESET_PC=0x100, en=1, done=1 valid=1 every cycle, dec_rdy=1 -> req addrs 0x100,0x104,0x108...; dec_pc trails by one cycle; rdy=1 each cycle.
- dec_rdy=0, DEPTH=4 -> exactly 4 completions then inst_req_en=0 at pc=0x110; raise dec_rdy -> entries 0x100..0x10C delivered in order, fetching resumes.
- Fetch at 0x208 returns valid=0 -> entry {pc=0x208, fault=1} delivered, inst_req_en stays 0; redirect_pc=0x400 -> next req addr 0x400, halted cleared.
- Buffer holding 3 entries, redirect_en with redirect_pc=0x3002 and dec_rdy=1 same cycle -> next cycle dec_valid=0, req addr 0x3000, count 0.
- done held low 5 cycles -> addr steady at pc, no push; en dropped mid-wait -> request withdrawn, pc unchanged.
- Assert rst mid-stream with full buffer -> immediately dec_valid=0, inst_req_en=0; after release first addr = RESET_PC.
